// File: rtl/psk_pkg.sv
// Shared definitions for the PSK receive packer and its output FIFO.
//   BITS_PER_BYTE   : bits per packed output byte
//   BPSK/QPSK_SYM_W : bits carried per symbol decision
//   MODE_*          : mode encoding (1 = BPSK), same as the modulator's out_is_bpsk
//   pack_state_t    : packer FSM states
//   rx_beat_t       : one output beat (byte, frame-end flag, BPSK flag)
package psk_pkg;

   localparam int unsigned BITS_PER_BYTE = 8;
   localparam int unsigned BPSK_SYM_W    = 1;
   localparam int unsigned QPSK_SYM_W    = 2;

   localparam logic MODE_BPSK = 1'b1;
   localparam logic MODE_QPSK = 1'b0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PACK = 1'b1
   } pack_state_t;

   typedef struct packed {
      logic [BITS_PER_BYTE-1:0] data;
      logic                     last;
      logic                     user;
   } rx_beat_t;

endpackage

// File: rtl/psk_rx_fifo.sv
// Synchronous first-word fall-through FIFO with registered outputs.
//   clk, rst_n : clock, synchronous active-low reset
//   push       : write push_beat (accepted if not full, or full with a pop)
//   push_beat  : beat to write
//   pop_rdy    : downstream ready; a pop happens on out_vld & pop_rdy
//   out_beat   : head beat, held stable while not popped
//   out_vld    : head beat valid
//   full/empty : occupancy flags
module psk_rx_fifo
   import psk_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  rx_beat_t push_beat,
   input  logic     pop_rdy,
   output rx_beat_t out_beat,
   output logic     out_vld,
   output logic     full,
   output logic     empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   rx_beat_t             mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     rd_ptr_n;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     count_n;
   logic                 pop;
   logic                 push_ok;
   rx_beat_t             head_n;

   // Next-state view; outputs are registered from it so they track storage
   always_comb begin
      pop      = out_vld & pop_rdy;
      push_ok  = push & (~full | pop);
      count_n  = count + CNT_W'(push_ok) - CNT_W'(pop);
      rd_ptr_n = rd_ptr + PTR_W'(pop);
      // A write into an otherwise empty FIFO becomes the head directly
      if (push_ok && ((count - CNT_W'(pop)) == '0))
         head_n = push_beat;
      else
         head_n = mem[rd_ptr_n];
   end

   // Storage array, written only on accepted pushes
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_beat;
   end

   // Pointers, occupancy and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         out_beat <= '0;
         out_vld  <= 1'b0;
         full     <= 1'b0;
         empty    <= 1'b1;
      end else begin
         wr_ptr   <= wr_ptr + PTR_W'(push_ok);
         rd_ptr   <= rd_ptr_n;
         count    <= count_n;
         out_beat <= head_n;
         out_vld  <= (count_n != '0);
         full     <= (count_n == CNT_W'(DEPTH));
         empty    <= (count_n == '0);
      end
   end

endmodule

// File: rtl/psk_demod_packer.sv
// Packs BPSK/QPSK hard decisions MSB-first into bytes and streams them out
// over AXI-Stream through a small FIFO (input cannot be back-pressured).
//   clk_16d384M, rst_n_16d384M : clock, synchronous active-low reset
//   sym_vld/sym_bits/sym_is_bpsk/sym_last : symbol decision strobe and qualifiers
//   clr_err       : clears the sticky overflow flag
//   m_axis_*      : byte stream; tlast = frame end, tuser = frame was BPSK
//   overflow      : sticky, a byte was dropped because the FIFO was full
//   frame_cnt     : frames whose final byte entered the FIFO (wraps)
module psk_demod_packer
   import psk_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk_16d384M,
   input  logic                 rst_n_16d384M,
   input  logic                 sym_vld,
   input  logic [1:0]           sym_bits,
   input  logic                 sym_is_bpsk,
   input  logic                 sym_last,
   input  logic                 clr_err,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tuser,
   output logic                 overflow,
   output logic [CNT_WIDTH-1:0] frame_cnt
);

   localparam int unsigned BCNT_W = 4;

   pack_state_t              state;
   logic                     mode;
   logic [BITS_PER_BYTE-2:0] sreg;
   logic [BCNT_W-1:0]        bit_cnt;
   logic                     push_vld;
   rx_beat_t                 push_beat;

   logic                     eff_mode;
   logic [BITS_PER_BYTE-1:0] shifted;
   logic [BITS_PER_BYTE-1:0] aligned;
   logic [BCNT_W-1:0]        new_cnt;
   logic                     byte_done;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     pop_c;
   logic                     drop_c;
   rx_beat_t                 fifo_beat;

   // Symbol insertion; mode is taken from the first symbol of a frame only
   always_comb begin
      eff_mode  = (state == ST_IDLE) ? sym_is_bpsk : mode;
      shifted   = (eff_mode == MODE_BPSK) ? {sreg, sym_bits[0]}
                                          : {sreg[BITS_PER_BYTE-3:0], sym_bits};
      new_cnt   = bit_cnt + ((eff_mode == MODE_BPSK) ? BCNT_W'(BPSK_SYM_W)
                                                     : BCNT_W'(QPSK_SYM_W));
      byte_done = (new_cnt == BCNT_W'(BITS_PER_BYTE)) | sym_last;
      // Left-align a short final byte, zero-filling the LSBs
      aligned   = shifted << (BCNT_W'(BITS_PER_BYTE) - new_cnt);
      pop_c     = m_axis_tready & ~fifo_empty;
      drop_c    = push_vld & fifo_full & ~pop_c;
   end

   // Packer FSM, push stage, overflow flag and frame counter
   always_ff @(posedge clk_16d384M) begin
      if (!rst_n_16d384M) begin
         state     <= ST_IDLE;
         mode      <= MODE_QPSK;
         sreg      <= '0;
         bit_cnt   <= '0;
         push_vld  <= 1'b0;
         push_beat <= '0;
         overflow  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         push_vld <= 1'b0;
         if (sym_vld) begin
            mode  <= eff_mode;
            state <= sym_last ? ST_IDLE : ST_PACK;
            if (byte_done) begin
               push_vld       <= 1'b1;
               push_beat.data <= aligned;
               push_beat.last <= sym_last;
               push_beat.user <= eff_mode;
               sreg           <= '0;
               bit_cnt        <= '0;
            end else begin
               sreg    <= shifted[BITS_PER_BYTE-2:0];
               bit_cnt <= new_cnt;
            end
         end
         // A new drop wins over a simultaneous clear
         if (drop_c)
            overflow <= 1'b1;
         else if (clr_err)
            overflow <= 1'b0;
         if (push_vld && push_beat.last && !drop_c)
            frame_cnt <= frame_cnt + CNT_WIDTH'(1);
      end
   end

   psk_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_16d384M),
      .rst_n     (rst_n_16d384M),
      .push      (push_vld),
      .push_beat (push_beat),
      .pop_rdy   (m_axis_tready),
      .out_beat  (fifo_beat),
      .out_vld   (m_axis_tvalid),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign m_axis_tdata = fifo_beat.data;
   assign m_axis_tlast = fifo_beat.last;
   assign m_axis_tuser = fifo_beat.user;

endmodule

// File: doc/psk_demod_packer.md
Name: psk_demod_packer

Overview:
Receive-side counterpart of the PSK modulation chain. Accepts hard symbol decisions (1 bit BPSK / 2 bits QPSK) from the demodulator/slicer as one-cycle strobes in the 16.384 MHz domain. Packs them MSB-first into bytes and emits an AXI-Stream byte stream carrying tlast (frame end) and tuser (BPSK flag). Buffers the output in a small FIFO, because the symbol input cannot be back-pressured; the stream then goes to the CDC FIFO toward the 1.024 MHz domain.

Parameters:
FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)
CNT_WIDTH, 16, width of frame counter

Ports:
clk_16d384M  in  1  system clock
rst_n_16d384M  in  1  reset, synchronous, active-low
sym_vld  in  1  one-cycle strobe, symbol decision valid (≤1 per 16 clocks nominal, any spacing legal)
sym_bits  in  2  decision; QPSK: [1] earlier bit, [0] later bit; BPSK: [0] only
sym_is_bpsk  in  1  mode of current symbol
sym_last  in  1  qualifies sym_vld: final symbol of frame
clr_err  in  1  one-cycle pulse, clears sticky flags
m_axis_tdata  out  8  packed byte
m_axis_tvalid  out  1  byte valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last byte of frame
m_axis_tuser  out  1  1 = frame was BPSK
overflow  out  1  sticky, byte dropped due to full FIFO
frame_cnt  out  CNT_WIDTH  frames fully pushed into FIFO, wraps at 2^CNT_WIDTH

Behaviour:
- Reset (rst_n_16d384M=0 at clock edge): shift reg=0, bit count=0, state=IDLE, FIFO emptied. m_axis_tvalid=0, tdata=0, tlast=0, tuser=0, overflow=0, frame_cnt=0. Reset mid-byte or mid-frame discards partial data silently.
- FSM states: IDLE, PACK.
  - IDLE --sym_vld--> PACK. Latches mode = sym_is_bpsk for the whole frame. sym_is_bpsk is ignored on later symbols until the frame ends.
  - PACK --sym_vld & sym_last--> IDLE, after the final byte is pushed.
  - sym_vld & sym_last in IDLE gives a single-symbol frame: push one padded byte, stay in IDLE.
- Packing: shift left by 1 (BPSK, inserts sym_bits[0]) or 2 (QPSK, inserts sym_bits[1:0]). Bit count advances 1 or 2.
  - Count reaching 8 pushes the byte, tlast=sym_last, tuser=mode; count returns to 0.
  - sym_last with count<8 left-aligns the partial byte, zero-pads the LSBs, and pushes it with tlast=1.
- Push occurs on the cycle after the completing sym_vld. With the FIFO empty, m_axis_tvalid rises 2 cycles after that sym_vld edge.
- FIFO: registered outputs, first-word fall-through. Pop on tvalid & tready. tdata/tlast/tuser held stable while tvalid & !tready.
  - Push and pop in the same cycle while full: both succeed, no overflow.
- Overflow: push while full and no pop drops the byte (including its tlast) and sets overflow. overflow stays 1 until clr_err or reset. clr_err coinciding with a new overflow: set wins.
- frame_cnt increments when a tlast byte is successfully pushed, not when it is dropped.
- Any sym_vld gap is legal. Back-to-back sym_vld on consecutive cycles must be handled without loss while the FIFO is not full.

Decomposition:
- Package psk_pkg:
  - BITS_PER_BYTE=8.
  - Symbol widths BPSK=1, QPSK=2.
  - Mode encoding (1=BPSK), shared with the modulator's out_is_bpsk.
  - FSM state enum.
- One sub-module: psk_rx_fifo, a sync FIFO of width 10 (data, last, user) and depth FIFO_DEPTH, with full/empty flags.
- Packer FSM and counters live in the top level.

Test Plan:
- QPSK frame of 4 symbols 10,11,00,01, last on the 4th, tready=1 -> one beat tdata=0xB1, tlast=1, tuser=0, 2 cycles after last sym_vld; frame_cnt=1.
- BPSK frame of bits 1,0,1,0,0,1,0,1 then 1,1,1,1,0,0,0,0 (last on the 16th) -> beats 0xA5 (tlast=0, tuser=1), 0xF0 (tlast=1, tuser=1).
- QPSK partial: symbols 11,11,11 with last on the 3rd -> 0xFC, tlast=1. Next frame BPSK single bit 1 with last -> 0x80, tlast=1, tuser=1; sym_is_bpsk toggling mid-frame has no effect.
- tready=0 while 5 QPSK bytes arrive (FIFO_DEPTH=4) -> 4 bytes held in order with stable outputs, 5th dropped, overflow=1. Then tready=1 -> 4 beats drain; clr_err -> overflow=0.
- Full FIFO with simultaneous push and pop (tready=1 on the push cycle) -> no drop, overflow stays 0, byte order preserved.
- Reset asserted after 5 BPSK bits -> tvalid=0, frame_cnt=0. A following clean QPSK frame 00,00,11,11 + last -> 0x0F with no residue from the discarded bits.
